// File: rtl/fifo_dequeue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_dequeue_stage
//  Purpose  : Two-entry skid stage pulling from an upstream queue and
//             presenting entries to a ready/valid consumer.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_dequeue_stage #(
   parameter int DATA_WIDTH = 32,
   parameter     ID         = "DQSTAGE"
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  FLUSH_IN,
   input  logic                  RECOVER,
   input  logic                  EMPTY_IN,
   input  logic [DATA_WIDTH-1:0] Q_IN,
   output logic                  DQ_OUT,
   output logic                  VALID_OUT,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   input  logic                  READY_IN,
   output logic [1:0]            OCC_OUT,
   output logic [15:0]           ISSUED_OUT
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ONE  = 2'd1,
      ST_TWO  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_main;
   logic [DATA_WIDTH-1:0] r_skid;
   logic [DATA_WIDTH-1:0] w_main_nxt;
   logic [DATA_WIDTH-1:0] w_skid_nxt;
   logic [15:0]           r_issued;
   logic                  w_fill;
   logic                  w_valid;
   logic                  w_xfer;

   // Dequeue is decided from occupancy alone so the upstream path never sees READY_IN.
   assign w_fill  = !EMPTY_IN && (r_state != ST_TWO) && !FLUSH_IN && !RECOVER && !RESET;
   assign w_valid = !RESET && (r_state != ST_IDLE);
   assign w_xfer  = w_valid && READY_IN;

   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      if (FLUSH_IN) begin
         w_state_nxt = ST_IDLE;
      end else if (RECOVER) begin
         // Only a stalled presented entry survives recovery.
         w_state_nxt = (w_valid && !READY_IN) ? ST_ONE : ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_fill) begin
                  w_main_nxt  = Q_IN;
                  w_state_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_fill && w_xfer) begin
                  w_main_nxt = Q_IN;
               end else if (w_fill) begin
                  w_skid_nxt  = Q_IN;
                  w_state_nxt = ST_TWO;
               end else if (w_xfer) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_TWO: begin
               if (w_xfer) begin
                  w_main_nxt  = r_skid;
                  w_state_nxt = ST_ONE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state  <= ST_IDLE;
         r_main   <= '0;
         r_skid   <= '0;
         r_issued <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_main  <= w_main_nxt;
         r_skid  <= w_skid_nxt;
         if (w_xfer) begin
            r_issued <= r_issued + 16'd1;
         end
      end
   end

   always_comb begin
      OCC_OUT = 2'd0;
      if (!RESET) begin
         case (r_state)
            ST_ONE:  OCC_OUT = 2'd1;
            ST_TWO:  OCC_OUT = 2'd2;
            default: OCC_OUT = 2'd0;
         endcase
      end
   end

   assign DQ_OUT     = w_fill;
   assign VALID_OUT  = w_valid;
   assign DATA_OUT   = RESET ? '0 : r_main;
   assign ISSUED_OUT = r_issued;

   a_no_fill_when_full : assert property (@(posedge CLK) disable iff (RESET)
      !(w_fill && (r_state == ST_TWO)))
      else $error("%s: dequeue strobe raised with both slots occupied", ID);

endmodule
`default_nettype wire

// File: doc/fifo_dequeue_stage.md
FIFO_DEQUEUE_STAGE -- requirements
Module: fifo_dequeue_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the width of the queue entry and of the output payload.
REQ-002 Parameter ID, default "DQSTAGE", is the instance name string used only in simulation messages.
REQ-003 CLK  input  1  sole clock; all state changes occur on its rising edge.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 FLUSH_IN  input  1  discards all held entries.
REQ-006 RECOVER  input  1  branch-recovery request; keeps only an entry already presented and stalled.
REQ-007 EMPTY_IN  input  1  empty flag from the upstream queue.
REQ-008 Q_IN  input  DATA_WIDTH  head entry of the upstream queue, valid whenever EMPTY_IN=0.
REQ-009 DQ_OUT  output  1  dequeue strobe to the upstream queue; the head is consumed in the same cycle.
REQ-010 VALID_OUT  output  1  DATA_OUT holds a valid entry for the consumer.
REQ-011 DATA_OUT  output  DATA_WIDTH  payload presented to the consumer.
REQ-012 READY_IN  input  1  consumer accepts DATA_OUT in this cycle.
REQ-013 OCC_OUT  output  2  number of entries held: 0, 1 or 2.
REQ-014 ISSUED_OUT  output  16  running count of completed consumer transfers.

Function
REQ-015 Storage: two registers, MAIN (drives DATA_OUT) and SKID; the FSM has states IDLE (0 entries), ONE (MAIN valid) and TWO (MAIN and SKID valid).
REQ-016 DQ_OUT = !EMPTY_IN && state!=TWO && !FLUSH_IN && !RECOVER && !RESET; it is combinational and SHALL NOT depend on READY_IN.
REQ-017 VALID_OUT = (state!=IDLE); OCC_OUT = 0/1/2 for IDLE/ONE/TWO.
REQ-018 Transfer: xfer = VALID_OUT && READY_IN; fill = DQ_OUT.
REQ-019 IDLE: on fill, MAIN<=Q_IN and state goes to ONE; otherwise the FSM stays in IDLE.
REQ-020 ONE: fill with xfer loads MAIN<=Q_IN and stays in ONE; fill without xfer loads SKID<=Q_IN and goes to TWO; xfer without fill goes to IDLE; neither holds state.
REQ-021 TWO: on xfer, MAIN<=SKID and state goes to ONE; no fill occurs in TWO; no xfer holds state.
REQ-022 Order: entries reach DATA_OUT in exactly upstream dequeue order, with no loss or duplication.
REQ-023 Latency: an entry dequeued in cycle N appears on DATA_OUT in cycle N+1 when it enters MAIN directly.
REQ-024 Throughput: with READY_IN held high and the queue non-empty, one transfer occurs per cycle.
REQ-025 DATA_OUT and MAIN SHALL stay stable while VALID_OUT=1 and READY_IN=0.
REQ-026 FLUSH_IN=1 takes precedence over RECOVER: the next state is IDLE and both entries are dropped. The xfer in the flush cycle still counts if VALID_OUT && READY_IN.
REQ-027 RECOVER=1, FLUSH_IN=0: SKID is always dropped. If VALID_OUT && !READY_IN, MAIN is kept and the next state is ONE; otherwise the next state is IDLE.
REQ-028 ISSUED_OUT increments by 1 on every xfer, wraps from 16'hFFFF to 0, and is not cleared by FLUSH_IN or RECOVER.
REQ-029 SKID contents are don't-care outside TWO. DATA_OUT is don't-care when VALID_OUT=0, but is zero after reset.

Reset
REQ-030 When RESET=1 at a rising edge: state<=IDLE, MAIN<=0, SKID<=0, ISSUED_OUT<=0.
REQ-031 While RESET=1: DQ_OUT=0, VALID_OUT=0, OCC_OUT=0, DATA_OUT=0.
REQ-032 Reset asserted mid-operation (state TWO, stalled) drops both entries. No transfer is counted in that cycle.
REQ-033 RESET has priority over FLUSH_IN and RECOVER.

Verification
REQ-034 Queue holds A,B,C and READY_IN=1 constantly -> DQ_OUT high for 3 cycles; DATA_OUT shows A,B,C on consecutive cycles; ISSUED_OUT=3.
REQ-035 Queue holds A,B,C and READY_IN=0 -> DQ_OUT pulses twice, OCC_OUT=2, DQ_OUT stays low, DATA_OUT=A stable. Raise READY_IN -> A,B,C delivered in order with no bubbles after the first.
REQ-036 State TWO (A in MAIN, B in SKID), READY_IN=0, RECOVER pulse -> OCC_OUT=1, DATA_OUT=A, B gone; DQ_OUT=0 in the RECOVER cycle.
REQ-037 State TWO, FLUSH_IN and RECOVER together with READY_IN=1 -> A counted (ISSUED_OUT+1), next OCC_OUT=0, VALID_OUT=0.
REQ-038 Force ISSUED_OUT to 16'hFFFF (via 65535 transfers), then one more transfer -> ISSUED_OUT=0.
REQ-039 RESET asserted in state TWO for one cycle -> OCC_OUT=0, DATA_OUT=0, ISSUED_OUT=0. After release with the queue non-empty, DQ_OUT rises in the first cycle.
